imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writer side of the instruction memory: receives a program image as a byte
//   stream, assembles 32-bit instruction words and writes them to consecutive
//   10-bit instruction addresses starting at 0. Holds the fetch stage in reset
//   (cpu_hold) until a complete frame with a valid checksum has been written.
//   Sits between the host byte link (UART receiver) and the instruction RAM
//   write port; the fetch stage uses the read port.
// PARAMETERS
//   ADDR_W    10     instruction address width (word addressed)
//   SYNC_BYTE 8'hA5  frame start marker
// PORTS
//   clk         in   1       system clock, all state updates on rising edge
//   reset       in   1       asynchronous, active-high reset
//   rx_data     in   8       incoming byte
//   rx_valid    in   1       rx_data valid this cycle
//   rx_ready    out  1       loader accepts byte; transfer = rx_valid & rx_ready
//   reload      in   1       one-cycle pulse: restart from DONE/ERROR
//   mem_we      out  1       instruction RAM write enable (1-cycle pulse)
//   mem_addr    out  ADDR_W  write word address
//   mem_wdata   out  32      write data
//   cpu_hold    out  1       1 = keep fetch/PC in reset
//   load_done   out  1       frame loaded, checksum good
//   load_error  out  1       checksum mismatch
// BEHAVIOUR
// - Reset (async): state IDLE; mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1,
//   load_done=0, load_error=0; rx_ready forced 0 while reset high.
// - Frame: SYNC_BYTE, LEN_HI, LEN_LO, N words x 4 bytes big-endian (MSB first),
//   CHK. LEN = {LEN_HI[1:0],LEN_LO} = N-1 (N=1..1024); LEN_HI[7:2] ignored.
//   CHK = XOR of all data bytes only.
// - States: IDLE -> LEN_H -> LEN_L -> DATA -> CHECK -> DONE | ERROR.
//   IDLE: accept bytes; non-SYNC bytes consumed and dropped; SYNC -> LEN_H.
//   LEN_H/LEN_L: latch count; LEN_L -> DATA, clear byte index, addr, xor acc.
//   DATA: shift byte into word register, xor into acc; on 4th byte of word,
//     next cycle mem_we=1 for exactly one cycle with mem_addr=current word
//     address and mem_wdata=assembled word; address then increments.
//     After word index == LEN written -> CHECK. No address wrap: LEN=1023 ends
//     at address 1023.
//   CHECK: next byte compared to acc: equal -> DONE, else -> ERROR.
//   DONE: load_done=1, cpu_hold=0, rx_ready=0. ERROR: load_error=1,
//     cpu_hold=1, rx_ready=0.
//   reload in DONE/ERROR -> IDLE next cycle: cpu_hold=1, flags cleared,
//     mem_addr=0. reload ignored in other states.
// - rx_ready=1 in IDLE..CHECK, including the mem_we cycle: a byte may be
//   accepted every cycle; mem_wdata is a separate register from the shifter.
// - rx_valid gaps of any length allowed; no timeout.
// - Words already written before an ERROR remain in memory; no rollback.
// - Reset mid-frame aborts immediately; partial word never written.
// TESTING
// 1. A5,00,01,12,34,56,78,9A,BC,DE,F0,00 -> writes [0]=12345678,
//    [1]=9ABCDEF0, two mem_we pulses, then load_done=1, cpu_hold=0.
// 2. Same frame, CHK=01 -> two writes, load_error=1, cpu_hold=1, rx_ready=0;
//    reload -> IDLE, flags 0, resend good frame -> load_done=1.
// 3. Bytes 00,FF,3C before A5 then valid 1-word frame -> garbage dropped,
//    single write at addr 0.
// 4. LEN 03,FF, 4096 data bytes, correct CHK -> 1024 writes, last addr 1023,
//    load_done=1; back-to-back rx_valid every cycle, no byte lost.
// 5. Reset asserted after 2 data bytes of word 0 -> all outputs at reset
//    values, no mem_we; new frame starts writing at addr 0.
// 6. rx_valid with random 0-5 cycle gaps on frame of test 1 -> identical writes.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte link, instruction RAM write port and loader status
interface imem_loader_if #(parameter int ADDR_W = 10);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              reload;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_error;
   modport slave (
      input  rx_data, rx_valid, reload,
      output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
   );
   modport master (
      output rx_data, rx_valid, reload,
      input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a framed byte stream into 32-bit words, writes them to instruction RAM and releases the CPU on a good checksum
module imem_loader #(
   parameter int          ADDR_W    = 10,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic         clk,
   input  logic         reset,
   imem_loader_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_LEN_H, S_LEN_L, S_DATA, S_CHECK, S_DONE, S_ERROR} state_t;
   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_len, r_addr;
   logic [1:0]        r_idx;
   logic [23:0]       r_shift;
   logic [7:0]        r_acc;
   logic              r_we;
   logic [31:0]       r_wdata;
   logic              w_xfer, w_last_byte, w_last_word, w_final;
   assign w_xfer      = bus.rx_valid & bus.rx_ready;
   assign w_last_byte = r_idx == 2'd3;
   assign w_last_word = r_addr == r_len;
   assign w_final     = r_state == S_DONE || r_state == S_ERROR;
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   // frame sequencing; the final word's 4th byte moves straight to CHECK
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:          if (w_xfer && bus.rx_data == SYNC_BYTE) w_next = S_LEN_H;
         S_LEN_H:         if (w_xfer) w_next = S_LEN_L;
         S_LEN_L:         if (w_xfer) w_next = S_DATA;
         S_DATA:          if (w_xfer && w_last_byte && w_last_word) w_next = S_CHECK;
         S_CHECK:         if (w_xfer) w_next = (bus.rx_data == r_acc) ? S_DONE : S_ERROR;
         S_DONE, S_ERROR: if (bus.reload) w_next = S_IDLE;
         default:         w_next = S_IDLE;
      endcase
   end
   // status outputs; rx_ready is held low for as long as reset is asserted
   always_comb begin
      bus.rx_ready   = !reset && !w_final;
      bus.cpu_hold   = r_state != S_DONE;
      bus.load_done  = r_state == S_DONE;
      bus.load_error = r_state == S_ERROR;
   end
   // length latch, word assembly, checksum and write-port registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_len   <= '0;
         r_addr  <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_acc   <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
      end else begin
         r_we <= 1'b0;
         if (r_we && !w_last_word) r_addr <= r_addr + ADDR_W'(1);
         if (r_state == S_LEN_H && w_xfer) r_len[ADDR_W-1:8] <= bus.rx_data[ADDR_W-9:0];
         if (r_state == S_LEN_L && w_xfer) begin
            r_len[7:0] <= bus.rx_data;
            r_idx      <= '0;
            r_addr     <= '0;
            r_acc      <= '0;
         end
         if (r_state == S_DATA && w_xfer) begin
            r_shift <= {r_shift[15:0], bus.rx_data};
            r_acc   <= r_acc ^ bus.rx_data;
            r_idx   <= r_idx + 2'd1;
            if (w_last_byte) begin
               r_we    <= 1'b1;
               r_wdata <= {r_shift, bus.rx_data};
            end
         end
         if (w_final && bus.reload) r_addr <= '0;
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frame tests for the instruction memory loader
module tb_imem_loader;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [9:0]  wa[$];
   logic [31:0] wd[$];
   imem_loader_if #(.ADDR_W(10)) bus();
   imem_loader dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // record every write pulse, sampled mid-cycle
   always @(negedge clk)
      if (bus.mem_we) begin
         wa.push_back(bus.mem_addr);
         wd.push_back(bus.mem_wdata);
      end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [7:0] b);
      int n;
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      n = 0;
      while (!bus.rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
   endtask
   task automatic gap(input int c);
      repeat (c) begin
         @(negedge clk);
         bus.rx_valid = 1'b0;
      end
   endtask
   task automatic send_q(input logic [7:0] q[$], input bit gaps);
      foreach (q[i]) begin
         if (gaps) gap($urandom_range(0, 5));
         send(q[i]);
      end
      gap(1);
   endtask
   task automatic pulse_reload();
      @(negedge clk);
      bus.reload = 1'b1;
      @(negedge clk);
      bus.reload = 1'b0;
   endtask
   task automatic chk_done(input string t);
      chk({t, "_done"}, {31'd0, bus.load_done}, 32'd1);
      chk({t, "_err"},  {31'd0, bus.load_error}, 32'd0);
      chk({t, "_hold"}, {31'd0, bus.cpu_hold}, 32'd0);
      chk({t, "_rdy"},  {31'd0, bus.rx_ready}, 32'd0);
   endtask
   function automatic logic [7:0] big_byte(input int i);
      return 8'(i * 7 + 3);
   endfunction
   logic [7:0] f1[$] = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78,
                         8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
   logic [7:0] f2[$] = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78,
                         8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01};
   logic [7:0] f3[$] = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'hFC, 8'h00,
                         8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
   logic [7:0] f5a[$] = '{8'hA5, 8'h00, 8'h00, 8'h11, 8'h22};
   logic [7:0] f5b[$] = '{8'hA5, 8'h00, 8'h00, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
   initial begin
      logic [7:0]  f4[$];
      logic [7:0]  acc;
      logic [31:0] w;
      int bad;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.reload   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_we",    {31'd0, bus.mem_we}, 32'd0);
      chk("rst_addr",  {22'd0, bus.mem_addr}, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_hold",  {31'd0, bus.cpu_hold}, 32'd1);
      chk("rst_flags", {30'd0, bus.load_done, bus.load_error}, 32'd0);
      chk("rst_rdy",   {31'd0, bus.rx_ready}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_rdy", {31'd0, bus.rx_ready}, 32'd1);
      // two-word frame, good checksum
      wa.delete(); wd.delete();
      send_q(f1, 1'b0);
      chk("t1_n", wa.size(), 32'd2);
      chk("t1_a0", {22'd0, wa[0]}, 32'd0);
      chk("t1_d0", wd[0], 32'h12345678);
      chk("t1_a1", {22'd0, wa[1]}, 32'd1);
      chk("t1_d1", wd[1], 32'h9ABCDEF0);
      chk_done("t1");
      // bad checksum, then reload and resend
      pulse_reload();
      wa.delete(); wd.delete();
      send_q(f2, 1'b0);
      chk("t2_n", wa.size(), 32'd2);
      chk("t2_d1", wd[1], 32'h9ABCDEF0);
      chk("t2_err",  {31'd0, bus.load_error}, 32'd1);
      chk("t2_done", {31'd0, bus.load_done}, 32'd0);
      chk("t2_hold", {31'd0, bus.cpu_hold}, 32'd1);
      chk("t2_rdy",  {31'd0, bus.rx_ready}, 32'd0);
      pulse_reload();
      chk("t2_rl_flags", {30'd0, bus.load_done, bus.load_error}, 32'd0);
      chk("t2_rl_hold",  {31'd0, bus.cpu_hold}, 32'd1);
      chk("t2_rl_addr",  {22'd0, bus.mem_addr}, 32'd0);
      chk("t2_rl_rdy",   {31'd0, bus.rx_ready}, 32'd1);
      wa.delete(); wd.delete();
      send_q(f1, 1'b0);
      chk("t2_re_n", wa.size(), 32'd2);
      chk_done("t2_re");
      // leading garbage dropped, LEN_HI upper bits ignored
      pulse_reload();
      wa.delete(); wd.delete();
      send_q(f3, 1'b0);
      chk("t3_n", wa.size(), 32'd1);
      chk("t3_a0", {22'd0, wa[0]}, 32'd0);
      chk("t3_d0", wd[0], 32'hDEADBEEF);
      chk_done("t3");
      // full 1024-word image, back-to-back bytes
      pulse_reload();
      wa.delete(); wd.delete();
      f4 = '{8'hA5, 8'h03, 8'hFF};
      acc = 8'h00;
      for (int i = 0; i < 4096; i++) begin
         f4.push_back(big_byte(i));
         acc ^= big_byte(i);
      end
      f4.push_back(acc);
      send_q(f4, 1'b0);
      chk("t4_n", wa.size(), 32'd1024);
      bad = 0;
      for (int k = 0; k < 1024; k++) begin
         w = {big_byte(4*k), big_byte(4*k+1), big_byte(4*k+2), big_byte(4*k+3)};
         if (wa[k] !== 10'(k) || wd[k] !== w) bad++;
      end
      chk("t4_bad", bad, 32'd0);
      chk("t4_last_addr", {22'd0, wa[1023]}, 32'd1023);
      chk("t4_mem_addr", {22'd0, bus.mem_addr}, 32'd1023);
      chk_done("t4");
      // reset in the middle of word 0
      pulse_reload();
      wa.delete(); wd.delete();
      foreach (f5a[i]) send(f5a[i]);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("t5_we",    {31'd0, bus.mem_we}, 32'd0);
      chk("t5_addr",  {22'd0, bus.mem_addr}, 32'd0);
      chk("t5_wdata", bus.mem_wdata, 32'd0);
      chk("t5_hold",  {31'd0, bus.cpu_hold}, 32'd1);
      chk("t5_flags", {30'd0, bus.load_done, bus.load_error}, 32'd0);
      chk("t5_rdy",   {31'd0, bus.rx_ready}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("t5_nowr", wa.size(), 32'd0);
      send_q(f5b, 1'b0);
      chk("t5_n", wa.size(), 32'd1);
      chk("t5_a0", {22'd0, wa[0]}, 32'd0);
      chk("t5_d0", wd[0], 32'hCAFEBABE);
      chk_done("t5");
      // frame 1 with random idle gaps
      pulse_reload();
      wa.delete(); wd.delete();
      send_q(f1, 1'b1);
      chk("t6_n", wa.size(), 32'd2);
      chk("t6_a0", {22'd0, wa[0]}, 32'd0);
      chk("t6_d0", wd[0], 32'h12345678);
      chk("t6_a1", {22'd0, wa[1]}, 32'd1);
      chk("t6_d1", wd[1], 32'h9ABCDEF0);
      chk_done("t6");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
